gb_apu_wave_ram: RTL
====================

GB_APU_WAVE_RAM -- requirements
Module: gb_apu_wave_ram

Interface
REQ-001 SHALL provide parameter: INIT_BYTE, 8'h00, value loaded into all 16 wave bytes on reset.
REQ-002 SHALL provide port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: cpu_addr  input  4  CPU byte index (FF30h-FF3Fh mapped to 0-15).
REQ-005 SHALL provide port: cpu_wr  input  1  CPU write strobe, one access per cycle high.
REQ-006 SHALL provide port: cpu_rd  input  1  CPU read strobe.
REQ-007 SHALL provide port: cpu_wdata  input  8  CPU write data.
REQ-008 SHALL provide port: cpu_rdata  output  8  registered CPU read data.
REQ-009 SHALL provide port: cpu_rvalid  output  1  one-cycle pulse marking cpu_rdata valid.
REQ-010 SHALL provide port: ch_active  input  1  Ch3 currently playing.
REQ-011 SHALL provide port: wave_addr  input  4  Ch3 current byte index.
REQ-012 SHALL provide port: wave_fetch  input  1  Ch3 one-cycle pulse: byte at wave_addr fetched this cycle.
REQ-013 SHALL provide port: wave_data  output  8  ram[wave_addr], combinational.

Function
REQ-014 SHALL store 16 bytes; high nibble = first sample, low nibble = second.
REQ-015 wave_data SHALL reflect storage before the current edge; a same-cycle write to that byte appears the next cycle.
REQ-016 Effective CPU index: cpu_addr when ch_active=0; wave_addr when ch_active=1.
REQ-017 cpu_wr SHALL write cpu_wdata to the effective index at the edge, subject to REQ-021.
REQ-018 cpu_rd SHALL set cpu_rvalid=1 the next cycle, with cpu_rdata = byte at effective index sampled at the cycle of cpu_rd (latency 1).
REQ-019 cpu_wr and cpu_rd both high: write performed, read ignored, cpu_rvalid stays 0.
REQ-020 cpu_rdata SHALL hold its last value when cpu_rvalid=0.
REQ-021 Access window: a flag win SHALL be set the cycle after wave_fetch=1 and be high for exactly one cycle; back-to-back fetches keep it high each following cycle.
REQ-022 ch_active falling SHALL clear win the same edge; CPU accesses revert to cpu_addr immediately.
REQ-023 Address arithmetic 4-bit; index 15 to 0 wrap is the channel's responsibility, no range check.

Reset
REQ-024 reset SHALL load INIT_BYTE into all 16 bytes, cpu_rdata=8'hFF, cpu_rvalid=0, win=0.
REQ-025 reset SHALL take priority over any same-cycle cpu_wr/cpu_rd; a read pending from the prior cycle SHALL NOT produce cpu_rvalid.

Configuration
REQ-026 Macro GB_APU_WAVE_DMG_QUIRK_EN SHALL select DMG access behaviour.
REQ-027 Defined: with ch_active=1, CPU write takes effect only when win=1, else dropped; read returns byte at wave_addr when win=1, else 8'hFF (cpu_rvalid still pulses).
REQ-028 Undefined (CGB behaviour): with ch_active=1, CPU accesses always redirect to wave_addr regardless of win; win logic may be omitted.

Verification
REQ-029 Reset with INIT_BYTE=8'h00, then read all 16 indices with ch_active=0 -> each cpu_rdata=8'h00, cpu_rvalid one cycle after each cpu_rd.
REQ-030 ch_active=0, write 8'hF0 to index 5, read index 5 -> cpu_rdata=8'hF0; wave_addr=5 -> wave_data=8'hF0 the cycle after the write.
REQ-031 ch_active=1, wave_addr=3, ram[3]=8'hA5, cpu_rd at cpu_addr=9 one cycle after wave_fetch -> cpu_rdata=8'hA5 both configs; same read two cycles after fetch -> 8'hFF with macro, 8'hA5 without.
REQ-032 ch_active=1, wave_addr=7, cpu_wr 8'h3C at cpu_addr=0 outside window -> ram[7] unchanged, ram[0] unchanged with macro; ram[7]=8'h3C without.
REQ-033 cpu_wr and cpu_rd same cycle, index 2, data 8'h11 -> ram[2]=8'h11, no cpu_rvalid; reset asserted the cycle after a cpu_rd -> no cpu_rvalid, cpu_rdata=8'hFF.

Source files
------------

// File: rtl/gb_apu_wave_ram.sv
// Game Boy APU Ch3 wave pattern RAM: 16 bytes shared between the CPU port and the wave channel.
// Define GB_APU_WAVE_DMG_QUIRK_EN for DMG access-window behaviour; the default build is CGB behaviour.
module gb_apu_wave_ram #(
    parameter logic [7:0] INIT_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cpu_addr,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,
    input  logic       ch_active,
    input  logic [3:0] wave_addr,
    input  logic       wave_fetch,
    output logic [7:0] wave_data
);

    logic [7:0] ram_reg [16];
    logic [7:0] rdata_reg;
    logic [7:0] rdata_next;
    logic       rvalid_reg;
    logic [3:0] eff_addr;
    logic       access_ok;
    logic       rd_en;
    logic       wr_en;

    // While the channel plays, the CPU only ever sees the byte the channel is on.
    assign eff_addr = ch_active ? wave_addr : cpu_addr;

`ifdef GB_APU_WAVE_DMG_QUIRK_EN
    logic win_reg;

    // Window opens for the single cycle after a fetch; inactive channel closes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_reg <= 1'b0;
        end else begin
            win_reg <= ch_active & wave_fetch;
        end
    end

    assign access_ok = ~ch_active | win_reg;
`else
    logic unused_fetch;

    assign unused_fetch = wave_fetch;
    assign access_ok    = 1'b1;
`endif

    assign wr_en      = cpu_wr & access_ok;
    assign rd_en      = cpu_rd & ~cpu_wr;
    assign rdata_next = access_ok ? ram_reg[eff_addr] : 8'hFF;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                ram_reg[i] <= INIT_BYTE;
            end
        end else if (wr_en) begin
            ram_reg[eff_addr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_reg  <= 8'hFF;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= rd_en;
            if (rd_en) begin
                rdata_reg <= rdata_next;
            end
        end
    end

    assign cpu_rdata  = rdata_reg;
    assign cpu_rvalid = rvalid_reg;
    assign wave_data  = ram_reg[wave_addr];

endmodule
